// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the RV32I pipeline.
// Redirect has priority over stall on the PC; flush has priority over stall on IF/ID.
module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall_F,
  input  logic        stall_D,
  input  logic        flush_D,
  input  logic        pc_src_E,
  input  logic [31:0] pc_target_E,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [6:0]  op_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc_plus4_D,
  output logic        valid_D
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    if (pc_src_E)
      pc_d = {pc_target_E[31:2], 2'b00};
    else if (!stall_F && imem_ready)
      pc_d = pc_inc;
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_D) begin
      // PC fields still track the fetch address on a flush to aid debug.
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      pcd_d   = pc_q;
      pc4_d   = pc_inc;
    end else if (stall_D) begin
      instr_d = instr_q;
    end else if (!imem_ready || pc_src_E) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      instr_d = imem_rdata;
      pcd_d   = pc_q;
      pc4_d   = pc_inc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcd_q   <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc_F       = pc_q;
  assign instr_D    = instr_q;
  assign op_D       = instr_q[6:0];
  assign pc_D       = pcd_q;
  assign pc_plus4_D = pc4_q;
  assign valid_D    = valid_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed self-checking bench for fetch_ifid_stage with a combinational imem model.
module tb_fetch_ifid_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall_F, stall_D, flush_D, pc_src_E;
  logic [31:0] pc_target_E;
  logic [31:0] pc_F, instr_D, pc_D, pc_plus4_D;
  logic [6:0]  op_D;
  logic        valid_D;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  fetch_ifid_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
    .pc_src_E(pc_src_E), .pc_target_E(pc_target_E),
    .pc_F(pc_F), .instr_D(instr_D), .op_D(op_D), .pc_D(pc_D),
    .pc_plus4_D(pc_plus4_D), .valid_D(valid_D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0: mem = 32'h0050_0093;
      32'h4: mem = 32'h0010_0113;
      32'h8: mem = 32'h0020_81B3;
      default: mem = {a[24:0], 7'h33};
    endcase
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      assert (!(stall_D && !stall_F)) else begin
        mismatched++;
        $error("FAIL illegal_stall: observed stall_D=1 stall_F=0 expected stall_D<=stall_F");
      end
    end
  end

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; stall_F = 1'b0; stall_D = 1'b0;
    flush_D = 1'b0; pc_src_E = 1'b0; pc_target_E = '0;
    repeat (3) step();
    chk("rst_pcF", pc_F, 32'h0);
    chk("rst_instr", instr_D, 32'h13);
    chk("rst_op", {25'd0, op_D}, 32'h13);
    chk("rst_pcD", pc_D, 32'h0);
    chk("rst_pc4", pc_plus4_D, 32'h0);
    chk("rst_valid", {31'd0, valid_D}, 32'h0);
    rst_n = 1'b1;

    step();
    chk("f0_instr", instr_D, 32'h0050_0093);
    chk("f0_pcD", pc_D, 32'h0);
    chk("f0_pc4", pc_plus4_D, 32'h4);
    chk("f0_op", {25'd0, op_D}, 32'h13);
    chk("f0_valid", {31'd0, valid_D}, 32'h1);
    chk("f0_pcF", pc_F, 32'h4);
    step();
    chk("f1_instr", instr_D, 32'h0010_0113);
    chk("f1_pcD", pc_D, 32'h4);
    chk("f1_pcF", pc_F, 32'h8);

    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("ws_pcF", pc_F, 32'h8);
      chk("ws_instr", instr_D, 32'h13);
      chk("ws_valid", {31'd0, valid_D}, 32'h0);
    end
    imem_ready = 1'b1;
    step();
    chk("f2_instr", instr_D, 32'h0020_81B3);
    chk("f2_pcD", pc_D, 32'h8);
    chk("f2_pc4", pc_plus4_D, 32'hC);
    chk("f2_valid", {31'd0, valid_D}, 32'h1);
    chk("f2_pcF", pc_F, 32'hC);

    stall_F = 1'b1; stall_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_pcF", pc_F, 32'hC);
      chk("st_instr", instr_D, 32'h0020_81B3);
      chk("st_pcD", pc_D, 32'h8);
      chk("st_valid", {31'd0, valid_D}, 32'h1);
    end
    stall_F = 1'b0; stall_D = 1'b0;
    step();
    chk("f3_instr", instr_D, 32'h0000_0633);
    chk("f3_pcD", pc_D, 32'hC);
    chk("f3_pcF", pc_F, 32'h10);

    // Branch redirect with flush while the hazard unit also stalls.
    pc_src_E = 1'b1; pc_target_E = 32'h40; flush_D = 1'b1; stall_F = 1'b1; stall_D = 1'b1;
    step();
    chk("rd_pcF", pc_F, 32'h40);
    chk("rd_valid", {31'd0, valid_D}, 32'h0);
    chk("rd_instr", instr_D, 32'h13);
    chk("rd_pcD", pc_D, 32'h10);
    chk("rd_pc4", pc_plus4_D, 32'h14);
    pc_src_E = 1'b0; flush_D = 1'b0; stall_F = 1'b0; stall_D = 1'b0;
    step();
    chk("rd2_pcD", pc_D, 32'h40);
    chk("rd2_instr", instr_D, 32'h0000_2033);
    chk("rd2_pcF", pc_F, 32'h44);

    pc_src_E = 1'b1; pc_target_E = 32'h46;
    step();
    chk("mis_pcF", pc_F, 32'h44);
    chk("mis_valid", {31'd0, valid_D}, 32'h0);
    chk("mis_instr", instr_D, 32'h13);
    pc_src_E = 1'b0;
    step();
    chk("mis2_pcD", pc_D, 32'h44);
    chk("mis2_pcF", pc_F, 32'h48);

    pc_src_E = 1'b1; flush_D = 1'b1; pc_target_E = 32'hFFFF_FFFC;
    step();
    chk("wr_pcF", pc_F, 32'hFFFF_FFFC);
    pc_src_E = 1'b0; flush_D = 1'b0;
    step();
    chk("wr_pcD", pc_D, 32'hFFFF_FFFC);
    chk("wr_pc4", pc_plus4_D, 32'h0);
    chk("wr_pcF", pc_F, 32'h0);
    chk("wr_instr", instr_D, 32'hFFFF_FE33);
    chk("wr_valid", {31'd0, valid_D}, 32'h1);

    stall_F = 1'b1; stall_D = 1'b1;
    step();
    chk("ar_pre_pcF", pc_F, 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_pcF", pc_F, 32'h0);
    chk("ar_valid", {31'd0, valid_D}, 32'h0);
    chk("ar_instr", instr_D, 32'h13);
    chk("ar_pcD", pc_D, 32'h0);
    chk("ar_pc4", pc_plus4_D, 32'h0);
    stall_F = 1'b0; stall_D = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I pipeline. Holds the PC and drives the instruction-memory address. Latches each fetched word together with its PC and PC+4. Presents `op_D` directly to the instruction decoder in Decode. Honors stall, flush and Execute-stage redirect from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) inserted on flush, reset or fetch miss.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  fetch address, equals pc_F.
- imem_rdata  in  32  instruction word, combinational from imem_addr.
- imem_ready  in  1  imem_rdata valid this cycle; 0 = wait state.
- stall_F  in  1  hold PC.
- stall_D  in  1  hold IF/ID register.
- flush_D  in  1  replace IF/ID contents with bubble.
- pc_src_E  in  1  taken branch/jump redirect from Execute.
- pc_target_E  in  32  redirect target.
- pc_F  out  32  current fetch PC.
- instr_D  out  32  latched instruction.
- op_D  out  7  instr_D[6:0], to decoder.
- pc_D  out  32  PC of instr_D.
- pc_plus4_D  out  32  pc_D + 4.
- valid_D  out  1  instr_D is a real fetched instruction.

Behaviour:
- One clock. Reset is asynchronous and active-low. All state clears immediately when rst_n falls; rst_n is released synchronously by the environment.
- Reset values: pc_F=RESET_PC, instr_D=NOP_INSTR, pc_D=0, pc_plus4_D=0, valid_D=0. A reset asserted mid-fetch or mid-stall discards everything.
- Fetch completes in a cycle where imem_ready=1. Latency is 1 cycle from pc_F to instr_D on a hit.
- PC next-state, evaluated in priority order:
  - pc_src_E=1: pc_F <= {pc_target_E[31:2],2'b00}. Overrides stall_F and imem_ready. The in-flight fetch is discarded.
  - stall_F=1: hold.
  - imem_ready=0: hold and retry the same address.
  - otherwise: pc_F <= pc_F+4. Arithmetic is mod 2^32; 32'hFFFF_FFFC wraps to 0.
- IF/ID next-state, evaluated in priority order:
  - flush_D=1: instr_D=NOP_INSTR, valid_D=0. pc_D and pc_plus4_D load pc_F and pc_F+4 (debug only). Flush beats stall_D.
  - stall_D=1: hold all IF/ID fields.
  - imem_ready=0 or pc_src_E=1: bubble, i.e. instr_D=NOP_INSTR, valid_D=0.
  - otherwise: instr_D=imem_rdata, pc_D=pc_F, pc_plus4_D=pc_F+4, valid_D=1.
- pc_plus4_D is always pc_D+4 mod 2^32 when loaded from a fetch.
- op_D is a pure wire of instr_D[6:0]. After reset op_D=7'b0010011.
- The hazard unit asserts stall_F and stall_D together. stall_D=1 with stall_F=0 is illegal; behaviour is unspecified and flagged by a bench assertion.
- Simultaneous pc_src_E and flush_D (the normal branch case): PC redirects, and IF/ID takes a bubble.
- No other internal state; every register listed above is reset.

Test Plan:
- Reset then straight-line fetch. rst_n low 3 cycles, then imem returns 0x00500093, 0x00100113, 0x002081B3 at 0/4/8 with ready=1. Required: cycle 1 after release instr_D=0x00500093, pc_D=0, pc_plus4_D=4, op_D=0x13, valid_D=1. Then pc_D steps 4, 8, and pc_F reaches 12.
- Wait states. imem_ready=0 for 2 cycles at pc_F=8. Required: pc_F holds 8, instr_D=0x00000013 with valid_D=0 for 2 cycles. On ready=1, instr_D=imem word and pc_D=8.
- Stall. stall_F=stall_D=1 for 3 cycles while instr_D=0x002081B3, pc_D=8. Required: all outputs frozen and pc_F=12. After release, normal advance resumes.
- Redirect plus flush. pc_src_E=1, pc_target_E=0x40, flush_D=1 for 1 cycle, also with stall_F=1. Required: next cycle pc_F=0x40, valid_D=0, instr_D=0x13. The following cycle pc_D=0x40.
- Misaligned target and wrap. pc_target_E=0x00000046 gives pc_F=0x44. A redirect to 0xFFFFFFFC followed by a hit gives pc_D=0xFFFFFFFC, pc_plus4_D=0, pc_F=0.
- Async reset mid-stall. rst_n drops between clock edges during a stall. Required: pc_F=RESET_PC and valid_D=0 immediately, without waiting for a clock edge.
